// File: rtl/config_bus_arbiter_if.sv
// Requester, config-bus and response signals of config_bus_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface config_bus_arbiter_if #(
  parameter int addr_size    = 4,
  parameter int payload_size = 8,
  parameter int NUM_REQ      = 2
);
  localparam int W    = addr_size + payload_size + 1;
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req_val;
  logic [NUM_REQ-1:0]   req_rdy;
  logic [NUM_REQ*W-1:0] req_msg;
  logic [W-1:0]         cfg_send_msg;
  logic [W-1:0]         cfg_rec_msg;
  logic                 resp_val;
  logic                 resp_rdy;
  logic [ID_W-1:0]      resp_id;
  logic [W-1:0]         resp_msg;

  modport master (
    output req_val, req_msg, cfg_rec_msg, resp_rdy,
    input  req_rdy, cfg_send_msg, resp_val, resp_id, resp_msg
  );

  modport slave (
    input  req_val, req_msg, cfg_rec_msg, resp_rdy,
    output req_rdy, cfg_send_msg, resp_val, resp_id, resp_msg
  );
endinterface

// File: rtl/config_bus_arbiter.sv
// Round-robin arbiter sharing one config-register bus between NUM_REQ requesters,
// with one outstanding transaction, acknowledge timeout and a single response port.
module config_bus_arbiter #(
  parameter int addr_size    = 4,
  parameter int payload_size = 8,
  parameter int NUM_REQ      = 2,
  parameter int TIMEOUT      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  config_bus_arbiter_if.slave  bus
);
  localparam int W     = addr_size + payload_size + 1;
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int IDX_W = ID_W + 1;
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t               state;
  logic [ID_W-1:0]      last_grant;
  logic [ID_W-1:0]      grant;
  logic [addr_size-1:0] addr_q;
  logic [CNT_W-1:0]     cnt;
  logic [W-1:0]         send_q;
  logic [W-1:0]         resp_msg_q;
  logic                 resp_val_q;
  logic [ID_W-1:0]      resp_id_q;

  logic                 grant_found;
  logic [ID_W-1:0]      grant_idx;
  logic [IDX_W-1:0]     idx;
  logic [W-1:0]         sel_msg;
  logic [NUM_REQ-1:0]   rdy;
  logic                 hit;

  // Search upward from the requester after the last one served, wrapping once.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = {1'b0, last_grant} + IDX_W'(i);
      if (idx >= IDX_W'(NUM_REQ)) idx = idx - IDX_W'(NUM_REQ);
      if (!grant_found && bus.req_val[idx[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx[ID_W-1:0];
      end
    end
  end

  assign sel_msg = bus.req_msg[grant_idx*W +: W];

  always_comb begin
    rdy = '0;
    if (!reset && state == IDLE && grant_found) rdy[grant_idx] = 1'b1;
  end

  assign hit = bus.cfg_rec_msg[payload_size] &&
               (bus.cfg_rec_msg[W-1 -: addr_size] == addr_q);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      grant      <= '0;
      addr_q     <= '0;
      cnt        <= '0;
      send_q     <= '0;
      resp_msg_q <= '0;
      resp_val_q <= 1'b0;
      resp_id_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            grant  <= grant_idx;
            addr_q <= sel_msg[W-1 -: addr_size];
            if (sel_msg[payload_size]) begin
              send_q <= sel_msg;
              state  <= ISSUE;
            end else begin
              // Reads never touch the bus; they answer immediately with a failed, empty response.
              resp_msg_q <= {sel_msg[W-1 -: addr_size], 1'b0, {payload_size{1'b0}}};
              resp_val_q <= 1'b1;
              resp_id_q  <= grant_idx;
              state      <= RESP;
            end
          end
        end
        ISSUE: begin
          send_q <= '0;
          cnt    <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          if (hit) begin
            resp_msg_q <= bus.cfg_rec_msg;
            resp_val_q <= 1'b1;
            resp_id_q  <= grant;
            state      <= RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            resp_msg_q <= {addr_q, 1'b0, {payload_size{1'b0}}};
            resp_val_q <= 1'b1;
            resp_id_q  <= grant;
            state      <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (bus.resp_rdy) begin
            resp_val_q <= 1'b0;
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_rdy      = rdy;
  assign bus.cfg_send_msg = send_q;
  assign bus.resp_val     = resp_val_q;
  assign bus.resp_id      = resp_id_q;
  assign bus.resp_msg     = resp_msg_q;
endmodule

// File: doc/config_bus_arbiter.md
Name: config_bus_arbiter

Overview:
- Shares one configuration bus between NUM_REQ independent requesters, such as a host SPI bridge and an on-chip sequencer.
- Arbitrates round-robin and issues one config message at a time onto the bus feeding the configuration register(s).
- Waits for the register's registered acknowledge, or for a timeout, then returns a single response to the granted requester.
- Sits between requester val/rdy interfaces and the config-register chain.

Parameters:
- addr_size, 4, width of the config address field.
- payload_size, 8, width of the config payload field.
- NUM_REQ, 2, number of requesters (at least 1).
- TIMEOUT, 4, number of WAIT cycles before a missing acknowledge is declared a failure (at least 2).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_val  in  NUM_REQ  per-requester request valid.
- req_rdy  out  NUM_REQ  per-requester request accept (one-hot or zero).
- req_msg  in  NUM_REQ*W  packed requests, requester i at [i*W +: W]; W = addr_size+payload_size+1; field layout {addr, write, payload}.
- cfg_send_msg  out  W  message to the config register; all-zero when idle.
- cfg_rec_msg  in  W  registered response from the config register, {addr, success, payload}.
- resp_val  out  1  response valid.
- resp_rdy  in  1  response accepted, driven by the requester named on resp_id.
- resp_id  out  clog2(NUM_REQ) (minimum 1)  index of the requester that owns the response.
- resp_msg  out  W  response, {addr, success, payload}.

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE; cfg_send_msg=0, resp_val=0, resp_msg=0, resp_id=0, req_rdy=0; last_grant=NUM_REQ-1, so requester 0 wins first. An in-flight transaction is dropped with no response.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_val is high, grant the first asserted index searching upward from last_grant+1, with wrap-around.
  - req_rdy[grant]=1 combinationally in the same cycle.
  - On the clock edge, latch req_msg[grant] and grant into internal state.
  - If the latched write bit=1, go to ISSUE.
  - If the write bit=0, build resp_msg={addr,0,0} and go directly to RESP. The bus is not driven.
  - If no req_val is high, req_rdy=0 and the FSM stays in IDLE.
- ISSUE:
  - cfg_send_msg = latched message for exactly one cycle.
  - Timeout counter cleared to 0.
  - Next state is WAIT.
- WAIT:
  - cfg_send_msg=0.
  - Hit condition: cfg_rec_msg success bit [payload_size]=1 and its addr field equals the latched addr.
  - On a hit, latch resp_msg=cfg_rec_msg and go to RESP.
  - On a miss, increment the counter. When the counter reaches TIMEOUT-1 with no hit, resp_msg={addr,0,0} and go to RESP.
  - A hit and a timeout in the same cycle resolve as a hit.
- RESP:
  - resp_val=1, resp_id=latched grant, resp_msg held stable.
  - On resp_val && resp_rdy, go to IDLE and set last_grant=grant.
  - No new request is accepted until the following IDLE cycle, so a back-to-back transaction costs at least 1 idle cycle.
- Latency, write hit: accept cycle T (IDLE), bus driven in T+1, ack seen in T+2, resp_val high from T+3.
- Fairness: round-robin guarantees each persistently valid requester is served within NUM_REQ transactions.
- Exactly one transaction is outstanding at any time. req_rdy is never asserted outside IDLE.
- last_grant updates only on response handshake, not on reset-interrupted transactions.

Test Plan (addr_size=4, payload_size=8, NUM_REQ=2, TIMEOUT=4, register configured at addr 0):
- Single write: req0 msg=0x1A5 ({0,1,0xA5}) → req_rdy=01 at T; cfg_send_msg=0x1A5 at T+1 only; resp_val at T+3 with resp_msg=0x1A5, resp_id=0.
- Timeout: req1 msg=0x7A5 (addr 3) → 4 WAIT cycles, then resp_msg=0x600 (success 0, payload 0), resp_id=1.
- Non-write: req0 msg=0x0A5 → cfg_send_msg stays 0; resp_msg=0x000 one cycle after accept.
- Round-robin: both req_val held high with resp_rdy=1 → grants alternate 0,1,0,1 over 4 transactions.
- Response backpressure: resp_rdy=0 for 5 cycles → resp_val and resp_msg held constant; req_rdy=00 throughout; completes on the first resp_rdy=1.
- Mid-transaction reset: assert reset during WAIT → all outputs 0 immediately (asynchronous); after release, requester 0 is granted first.
